// File: rtl/mult_pkg.sv
// Shared definitions for the multiply sequencing controller.
//   state_e            : controller state encoding
//   MULT_LATENCY       : cycles the shift-add multiplier needs to finish
//   DEFAULT_MAX_CYCLES : default RUN-state watchdog limit
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned MULT_LATENCY       = 34;
  localparam int unsigned DEFAULT_MAX_CYCLES = 40;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair.
//   clk, rst      : clock, async active-low reset (clears HI and LO)
//   wr_hi/wr_lo   : move-to writes of wr_data (MTHI/MTLO)
//   prod_we       : load prod_hi/prod_lo (multiply result)
//   rd_hi/rd_lo   : read select (MFHI has priority over MFLO)
//   rd_data       : combinational read data, old value on same-cycle write
module hilo_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  input  logic        prod_we,
  input  logic [31:0] prod_hi,
  input  logic [31:0] prod_lo,
  input  logic        rd_hi,
  input  logic        rd_lo,
  output logic [31:0] rd_data
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (prod_we) begin
      hi_d = prod_hi;
      lo_d = prod_lo;
    end else begin
      if (wr_hi) hi_d = wr_data;
      if (wr_lo) lo_d = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_hi)      rd_data = hi_q;
    else if (rd_lo) rd_data = lo_q;
  end

endmodule

// File: rtl/mult_ctrl.sv
// Sequencing controller for the shared-ALU shift-add multiplier.
//   clk, rst                  : clock, async active-low reset
//   MultE/MfhiE/MfloE/        : Execute-stage MULT / move-from / move-to
//   MthiE/MtloE
//   SrcAE, SrcBE              : Execute operands (A also carries MTHI/MTLO data)
//   mul_completed/hi/lo       : multiplier done flag and product
//   mul_rst, mul_MultE        : multiplier clear pulse and enable
//   mul_SrcA, mul_SrcB        : operands latched at MULT issue
//   alu_sel_mult              : shared ALU owned by the multiplier (RUN only)
//   StallMD                   : stall request to the hazard unit
//   HiLoOut                   : MFHI/MFLO read data
//   busy, timeout_err         : not idle; sticky watchdog flag
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = DEFAULT_MAX_CYCLES,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MultE,
  input  logic        MfhiE,
  input  logic        MfloE,
  input  logic        MthiE,
  input  logic        MtloE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        mul_completed,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  output logic        mul_rst,
  output logic        mul_MultE,
  output logic [31:0] mul_SrcA,
  output logic [31:0] mul_SrcB,
  output logic        alu_sel_mult,
  output logic        StallMD,
  output logic [31:0] HiLoOut,
  output logic        busy,
  output logic        timeout_err
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        src_a_q, src_a_d;
  logic [31:0]        src_b_q, src_b_d;
  logic               timeout_err_q, timeout_err_d;
  // Marks that the current DONE came from the watchdog, so the product
  // (garbage) must not reach HI/LO. Separate from the sticky flag so later
  // multiplies still write back normally.
  logic               abort_q, abort_d;

  logic               wr_hi, wr_lo, prod_we;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    src_a_d       = src_a_q;
    src_b_d       = src_b_q;
    timeout_err_d = timeout_err_q;
    abort_d       = 1'b0;
    wr_hi         = 1'b0;
    wr_lo         = 1'b0;
    prod_we       = 1'b0;
    StallMD       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        StallMD = MultE;
        if (MultE) begin
          src_a_d = SrcAE;
          src_b_d = SrcBE;
          state_d = ST_CLEAR;
        end else begin
          wr_hi = MthiE;
          wr_lo = MtloE;
        end
      end
      ST_CLEAR: begin
        StallMD = 1'b1;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        StallMD = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (mul_completed) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          abort_d       = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        // MultE here is still the instruction just serviced; it leaves
        // Execute this cycle because StallMD is low.
        prod_we = ~abort_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      src_a_q       <= '0;
      src_b_q       <= '0;
      timeout_err_q <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      src_a_q       <= src_a_d;
      src_b_q       <= src_b_d;
      timeout_err_q <= timeout_err_d;
      abort_q       <= abort_d;
    end
  end

  // Held high during reset so the multiplier is cleared along with us.
  assign mul_rst      = ~rst | (state_q == ST_CLEAR);
  assign mul_MultE    = (state_q == ST_RUN);
  assign alu_sel_mult = (state_q == ST_RUN);
  assign mul_SrcA     = src_a_q;
  assign mul_SrcB     = src_b_q;
  assign busy         = (state_q != ST_IDLE);
  assign timeout_err  = timeout_err_q;

  hilo_regs u_hilo (
    .clk     (clk),
    .rst     (rst),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wr_data (SrcAE),
    .prod_we (prod_we),
    .prod_hi (mul_hi),
    .prod_lo (mul_lo),
    .rd_hi   (MfhiE),
    .rd_lo   (MfloE),
    .rd_data (HiLoOut)
  );

endmodule

// File: tb/tb_mult_ctrl.sv
module tb_mult_ctrl;
  import mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        MultE, MfhiE, MfloE, MthiE, MtloE;
  logic [31:0] SrcAE, SrcBE;
  logic        mul_completed;
  logic [31:0] mul_hi, mul_lo;
  logic        mul_rst, mul_MultE, alu_sel_mult, StallMD, busy, timeout_err;
  logic [31:0] mul_SrcA, mul_SrcB, HiLoOut;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural shift-add multiplier stand-in: completes MULT_LATENCY enabled
  // cycles after a clear, then parks with the product until cleared again.
  logic        tie0 = 1'b0;
  logic        m_done;
  int          m_cnt;
  logic [63:0] m_prod;
  assign m_prod        = {32'b0, mul_SrcA} * {32'b0, mul_SrcB};
  assign mul_completed = m_done & ~tie0;

  always @(posedge clk) begin
    if (mul_rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      mul_hi <= '0;
      mul_lo <= '0;
    end else if (mul_MultE && !m_done) begin
      if (m_cnt == int'(MULT_LATENCY) - 1) begin
        m_done <= 1'b1;
        mul_hi <= m_prod[63:32];
        mul_lo <= m_prod[31:0];
      end
      m_cnt <= m_cnt + 1;
    end
  end

  always #5 clk = ~clk;

  mult_ctrl #(.MAX_CYCLES(40), .CNT_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .MultE         (MultE),
    .MfhiE         (MfhiE),
    .MfloE         (MfloE),
    .MthiE         (MthiE),
    .MtloE         (MtloE),
    .SrcAE         (SrcAE),
    .SrcBE         (SrcBE),
    .mul_completed (mul_completed),
    .mul_hi        (mul_hi),
    .mul_lo        (mul_lo),
    .mul_rst       (mul_rst),
    .mul_MultE     (mul_MultE),
    .mul_SrcA      (mul_SrcA),
    .mul_SrcB      (mul_SrcB),
    .alu_sel_mult  (alu_sel_mult),
    .StallMD       (StallMD),
    .HiLoOut       (HiLoOut),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tg);
    MfhiE = 1'b1; MfloE = 1'b0; #1;
    check({tg, "_hi"}, HiLoOut, exp_hi);
    MfhiE = 1'b0; MfloE = 1'b1; #1;
    check({tg, "_lo"}, HiLoOut, exp_lo);
    MfloE = 1'b0; #1;
  endtask

  // Issues a MULT from IDLE and follows it through to IDLE again.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input int exp_runs, input string tg);
    int runs;
    logic run_ok;
    MultE = 1'b1; SrcAE = a; SrcBE = b; #1;
    check({tg, "_idle_stall"}, StallMD, 1);
    check({tg, "_idle_busy"}, busy, 0);
    step();
    check({tg, "_clr_rst"}, mul_rst, 1);
    check({tg, "_clr_stall"}, StallMD, 1);
    check({tg, "_clr_alu"}, alu_sel_mult, 0);
    check({tg, "_srca"}, mul_SrcA, a);
    check({tg, "_srcb"}, mul_SrcB, b);
    SrcAE = '0; SrcBE = '0;
    step();
    check({tg, "_run_rst"}, mul_rst, 0);
    runs = 0;
    run_ok = 1'b1;
    while (alu_sel_mult && runs < 100) begin
      runs++;
      if (!StallMD || !mul_MultE || !busy) run_ok = 1'b0;
      step();
    end
    check({tg, "_run_cycles"}, runs, exp_runs);
    check({tg, "_run_stall"}, run_ok, 1);
    check({tg, "_done_stall"}, StallMD, 0);
    check({tg, "_done_busy"}, busy, 1);
    check({tg, "_latch_hold"}, mul_SrcA, a);
    step();
    MultE = 1'b0; #1;
    check({tg, "_idle_after"}, busy, 0);
  endtask

  initial begin
    rst = 1'b0;
    MultE = 0; MfhiE = 0; MfloE = 0; MthiE = 0; MtloE = 0;
    SrcAE = '0; SrcBE = '0;
    #3;
    check("rst_mul_rst", mul_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_stall", StallMD, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_alu", alu_sel_mult, 0);
    step();
    rst = 1'b1; #1;
    check("rel_mul_rst", mul_rst, 0);
    read_hilo(32'h0, 32'h0, "rst_read");

    // 3 x 5
    do_mult(32'd3, 32'd5, 35, "m3x5");
    read_hilo(32'h0, 32'd15, "m3x5_res");

    // 0xFFFFFFFF x 2, MFHI immediately after
    do_mult(32'hFFFF_FFFF, 32'd2, 35, "mff");
    MfhiE = 1'b1; #1;
    check("mff_mfhi", HiLoOut, 32'h1);
    check("mff_mfhi_nostall", StallMD, 0);
    MfhiE = 1'b0;
    read_hilo(32'h1, 32'hFFFF_FFFE, "mff_res");

    // MTHI then MFHI
    MthiE = 1'b1; SrcAE = 32'hDEAD_BEEF;
    step();
    MthiE = 1'b0; MfhiE = 1'b1; #1;
    check("mthi_mfhi", HiLoOut, 32'hDEAD_BEEF);
    MfhiE = 1'b0;
    // MTLO + MFLO same cycle returns old LO
    MtloE = 1'b1; MfloE = 1'b1; SrcAE = 32'h1234_5678; #1;
    check("mtlo_rbw", HiLoOut, 32'hFFFF_FFFE);
    step();
    MtloE = 1'b0; #1;
    check("mtlo_after", HiLoOut, 32'h1234_5678);
    MfloE = 1'b0;

    // Timeout: HI=7 first; MULT issued with a same-cycle MTHI that must be dropped
    MthiE = 1'b1; SrcAE = 32'd7;
    step();
    tie0 = 1'b1;
    MthiE = 1'b1;
    do_mult(32'h99, 32'd3, 40, "tmo");
    MthiE = 1'b0; tie0 = 1'b0; #1;
    check("tmo_flag", timeout_err, 1);
    check("tmo_stall", StallMD, 0);
    read_hilo(32'd7, 32'h1234_5678, "tmo_keep");

    // Sticky flag survives a good multiply
    do_mult(32'd2, 32'd2, 35, "m2x2");
    check("sticky", timeout_err, 1);
    read_hilo(32'h0, 32'd4, "m2x2_res");

    // Reset in RUN cycle 10
    MultE = 1'b1; SrcAE = 32'd9; SrcBE = 32'd9;
    step(); step();
    for (int i = 0; i < 9; i++) step();
    check("mid_run", alu_sel_mult, 1);
    #2;
    rst = 1'b0; MultE = 1'b0; #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mulrst", mul_rst, 1);
    check("mid_rst_stall", StallMD, 0);
    check("mid_rst_tmo", timeout_err, 0);
    read_hilo(32'h0, 32'h0, "mid_rst_read");
    step();
    rst = 1'b1; #1;
    do_mult(32'd6, 32'd7, 35, "m6x7");
    read_hilo(32'h0, 32'd42, "m6x7_res");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
